// File: rtl/hall_dir_detect.sv
// hall_dir_detect: deglitches the Hall inputs and tracks BLDC commutation steps, direction, position, faults and stall.
module hall_dir_detect #(
  parameter int         FILT_DEPTH = 4,
  parameter int         CONFIRM_N  = 2,
  parameter int         CNT_W      = 4,
  parameter int         POS_W      = 16,
  parameter int         TIMEOUT    = 1000000,
  parameter logic [2:0] HALL_INV   = 3'b000,
  parameter bit         SEQ_REV    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       hall,
  input  logic             clr_pos,
  output logic [2:0]       hall_state,
  output logic             dir_out,
  output logic             dir_valid,
  output logic             step_pulse,
  output logic             step_dir,
  output logic [POS_W-1:0] pos_cnt,
  output logic             fault,
  output logic             skip_err,
  output logic             stall
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO1 = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CN = CNT_W'(CONFIRM_N);
  typedef enum logic {IDLE, TRACK} state_t;
  state_t state, state_n;
  logic [3*FILT_DEPTH-1:0] sr;
  logic [2:0] prev, prev_n, fw_code, rv_code;
  logic [CNT_W-1:0] fwd_cnt, rev_cnt, fwd_n, rev_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [POS_W-1:0] pos_n;
  logic step_n, sdir_n, fault_n, skip_n, stall_n, dout_n, dval_n, hs_valid;

  function automatic logic [2:0] nxt(input logic [2:0] c);
    return c == 3'b101 ? 3'b100 : c == 3'b100 ? 3'b110 : c == 3'b110 ? 3'b010 :
           c == 3'b010 ? 3'b011 : c == 3'b011 ? 3'b001 : c == 3'b001 ? 3'b101 : 3'b000;
  endfunction

  function automatic logic [2:0] prv(input logic [2:0] c);
    return c == 3'b100 ? 3'b101 : c == 3'b110 ? 3'b100 : c == 3'b010 ? 3'b110 :
           c == 3'b011 ? 3'b010 : c == 3'b001 ? 3'b011 : c == 3'b101 ? 3'b001 : 3'b000;
  endfunction

  assign hs_valid = |hall_state && !(&hall_state);
  assign fw_code  = SEQ_REV ? prv(prev) : nxt(prev);
  assign rv_code  = SEQ_REV ? nxt(prev) : prv(prev);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr         <= '0;
      hall_state <= '0;
      state      <= IDLE;
      prev       <= '0;
      fwd_cnt    <= '0;
      rev_cnt    <= '0;
      tmr        <= '0;
      pos_cnt    <= '0;
      step_pulse <= 1'b0;
      step_dir   <= 1'b0;
      fault      <= 1'b0;
      skip_err   <= 1'b0;
      stall      <= 1'b0;
      dir_out    <= 1'b0;
      dir_valid  <= 1'b0;
    end else begin
      sr         <= {sr[3*FILT_DEPTH-4:0], hall ^ HALL_INV};
      if (sr == {FILT_DEPTH{sr[2:0]}}) hall_state <= sr[2:0];
      state      <= state_n;
      prev       <= prev_n;
      fwd_cnt    <= fwd_n;
      rev_cnt    <= rev_n;
      tmr        <= tmr_n;
      pos_cnt    <= pos_n;
      step_pulse <= step_n;
      step_dir   <= sdir_n;
      fault      <= fault_n;
      skip_err   <= skip_n;
      stall      <= stall_n;
      dir_out    <= dout_n;
      dir_valid  <= dval_n;
    end

  // priority inside TRACK: fault > skip > step > stall timeout
  always_comb begin
    state_n = state;
    prev_n  = prev;
    fwd_n   = fwd_cnt;
    rev_n   = rev_cnt;
    tmr_n   = '0;
    pos_n   = clr_pos ? '0 : pos_cnt;
    step_n  = 1'b0;
    sdir_n  = step_dir;
    fault_n = 1'b0;
    skip_n  = 1'b0;
    stall_n = stall;
    dout_n  = fwd_cnt >= CN ? 1'b0 : rev_cnt >= CN ? 1'b1 : dir_out;
    dval_n  = dir_valid | fwd_cnt >= CN | rev_cnt >= CN;
    if (state == IDLE) begin
      if (hs_valid) begin
        state_n = TRACK;
        prev_n  = hall_state;
        fwd_n   = '0;
        rev_n   = '0;
      end
    end else begin
      tmr_n = tmr == TO1 ? tmr : tmr + TW'(1);
      if (!hs_valid) begin
        state_n = IDLE;
        fault_n = 1'b1;
        fwd_n   = '0;
        rev_n   = '0;
        tmr_n   = '0;
        dout_n  = dir_out;
        dval_n  = 1'b0;
      end else if (hall_state == fw_code || hall_state == rv_code) begin
        step_n  = 1'b1;
        sdir_n  = hall_state == rv_code;
        prev_n  = hall_state;
        tmr_n   = '0;
        stall_n = 1'b0;
        fwd_n   = sdir_n ? '0 : fwd_cnt + CNT_W'(~&fwd_cnt);
        rev_n   = sdir_n ? rev_cnt + CNT_W'(~&rev_cnt) : '0;
        pos_n   = clr_pos ? '0 : sdir_n ? pos_cnt - POS_W'(1) : pos_cnt + POS_W'(1);
      end else if (hall_state != prev) begin
        skip_n = 1'b1;
        fwd_n  = '0;
        rev_n  = '0;
        prev_n = hall_state;
        dout_n = dir_out;
        dval_n = dir_valid;
      end else if (tmr == TO1) begin
        stall_n = 1'b1;
        fwd_n   = '0;
        rev_n   = '0;
        dout_n  = dir_out;
        dval_n  = 1'b0;
      end
    end
  end
endmodule

// File: doc/hall_dir_detect.md
Name: hall_dir_detect

Overview:
Parametrised Hall-sensor direction and step detector for the flywheel BLDC drive. It deglitches the three Hall inputs and tracks commutation steps against the six-state sequence. It outputs a confirmed rotation direction, per-step pulses, a wrapping position count, and fault and stall flags. It feeds the speed-measurement and commutation-control logic.

Parameters:
FILT_DEPTH, 4, number of consecutive identical samples required before a Hall code is accepted (2..8).
CONFIRM_N, 2, consecutive same-direction steps required to confirm or flip direction (1..2^CNT_W-1).
CNT_W, 4, width of the step-run counters; they saturate at all-ones.
POS_W, 16, width of the position counter; it wraps modulo 2^POS_W.
TIMEOUT, 1000000, clk cycles without a valid step before stall is flagged (must be >= 2).
HALL_INV, 3'b000, per-bit input inversion applied to {c,b,a} before filtering.
SEQ_REV, 0, when 1, the meanings of forward and reverse are swapped.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hall  in  3  raw Hall inputs {c,b,a}, asynchronous to clk
clr_pos  in  1  synchronous clear of pos_cnt
hall_state  out  3  filtered Hall code
dir_out  out  1  confirmed direction: 0 = forward, 1 = reverse
dir_valid  out  1  dir_out is confirmed and the rotor is not stalled
step_pulse  out  1  one-cycle pulse on each valid adjacent step
step_dir  out  1  direction of the current step; qualified by step_pulse
pos_cnt  out  POS_W  signed position: +1 per forward step, -1 per reverse step
fault  out  1  one-cycle pulse when an invalid code (000 or 111) is accepted
skip_err  out  1  one-cycle pulse when a valid but non-adjacent transition occurs
stall  out  1  level; no valid step seen for TIMEOUT cycles

Behaviour:
- Reset values: all outputs 0, filter stages 000, tracker in IDLE, counters 0. Reset is asynchronous and may assert mid-operation; it returns everything to these values immediately.
- Filter:
  - Each cycle, hall^HALL_INV is shifted into a FILT_DEPTH-stage register.
  - When all stages are equal, hall_state loads that value on the next edge.
  - Latency: if the input changes and stays stable before edge k, hall_state shows the new code after edge k+FILT_DEPTH.
  - A glitch shorter than FILT_DEPTH cycles never reaches hall_state.
- Forward sequence (SEQ_REV=0): 101→100→110→010→011→001→101. Reverse is the opposite order.
- Tracker FSM, state IDLE:
  - Waits until hall_state is a valid code (not 000/111).
  - Then loads prev=hall_state, clears fwd_cnt and rev_cnt, and moves to TRACK.
  - No step_pulse is generated on this entry.
- Tracker FSM, state TRACK, evaluated when hall_state != prev:
  - Forward neighbour: step_pulse=1, step_dir=0, fwd_cnt+=1 (saturating), rev_cnt=0, pos_cnt+=1, prev updated.
  - Reverse neighbour: the mirror of the forward case, with step_dir=1 and pos_cnt-=1.
  - Invalid code: fault pulse, both counters cleared, dir_valid=0, go to IDLE. dir_out holds its value.
  - Valid but non-adjacent code: skip_err pulse, both counters cleared, prev updated, stay in TRACK. pos_cnt and dir_out are unchanged.
- Direction confirmation:
  - On the edge where fwd_cnt becomes >= CONFIRM_N: dir_out=0 and dir_valid=1. The same rule applies to rev_cnt with dir_out=1.
  - dir_out and dir_valid register one cycle after step_pulse.
  - A single opposite step clears the other counter. With CONFIRM_N=1 that single step flips dir_out.
- Stall timer:
  - Counts clk cycles in TRACK and is cleared on every step_pulse.
  - When it reaches TIMEOUT-1: stall=1, dir_valid=0, counters cleared. dir_out and pos_cnt hold.
  - stall clears on the edge of the next step_pulse.
  - In IDLE the timer is held at 0 and stall is held at 1 once it has been set.
- Priority on the same edge: fault > skip_err > step > stall timeout.
- clr_pos clears pos_cnt and takes priority over a same-cycle step; the step pulse still fires.
- pos_cnt wraps: 2^(POS_W-1)-1 plus a forward step gives -2^(POS_W-1).

Test Plan:
1. Reset, then drive forward codes 101,100,110 with each held 10 cycles (defaults) → hall_state follows each code 4 cycles after the change. step_pulse fires twice with step_dir=0. dir_out=0 and dir_valid=1 after the 2nd step. pos_cnt=2.
2. Hold 110, inject a 3-cycle pulse of 010 → hall_state stays 110, no step_pulse, no change on any output.
3. Forward-confirm, then step reverse 110→100→101 → the 1st reverse step does not flip. After the 2nd, dir_out=1 and pos_cnt drops by 2. Repeat with CONFIRM_N=1: the flip happens after the 1st step.
4. From 101, jump to 010 → skip_err pulse, pos_cnt unchanged, counters cleared. Then go to 000 → fault pulse, dir_valid=0, FSM in IDLE, dir_out held.
5. TIMEOUT=50: take two forward steps, then hold 50 cycles → stall=1 and dir_valid=0 at cycle 50. The next forward step clears stall. A 2nd step restores dir_valid=1.
6. POS_W=4: take 8 forward steps from 0 → pos_cnt=-8 (4'b1000). Assert clr_pos together with a step → pos_cnt=0 and step_pulse=1. Assert rst_n mid-run → all outputs 0 immediately.
